// File: rtl/usb_kbd_ascii.sv
// usb_kbd_ascii
//   Converts HID keyboard reports into US-layout ASCII characters and queues
//   them in a FIFO that the 6502 reads through a two-register window.
//   Each report is scanned one slot per cycle. A key is queued only when it
//   was not held in the previous report, so each press produces one character.
//
//   Optional build macro: KBD_REPEAT_EN enables auto-repeat of the most
//   recently pushed key while that key stays held.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   report_i         one-cycle pulse per HID report
//   typ_i            device type (1 = keyboard)
//   key_modifiers_i  HID modifier byte
//   key1_i..key4_i   HID usage codes of held keys (0 = empty slot)
//   kbd_cs           chip select; an access is the first cycle it is high
//   R_W_n            1 = read, 0 = write
//   reg_addr_i       register address (00 status, 01 FIFO head)
//   data_o           combinational read data
module usb_kbd_ascii #(
   parameter int unsigned FIFO_DEPTH       = 16,
   parameter int unsigned REPEAT_DELAY_CYC = 12500000,
   parameter int unsigned REPEAT_RATE_CYC  = 2500000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       report_i,
   input  logic [1:0] typ_i,
   input  logic [7:0] key_modifiers_i,
   input  logic [7:0] key1_i,
   input  logic [7:0] key2_i,
   input  logic [7:0] key3_i,
   input  logic [7:0] key4_i,
   input  logic       kbd_cs,
   input  logic       R_W_n,
   input  logic [7:0] reg_addr_i,
   output logic [7:0] data_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

   // HID usage code -> ASCII (US layout); 0 means "no character"
   function automatic logic [7:0] f_translate(input logic [7:0] code,
                                              input logic [7:0] mod);
      logic       ctrl;
      logic       shift;
      logic [7:0] ch;
      ctrl  = mod[0] | mod[4];
      shift = mod[1] | mod[5];
      ch    = '0;
      if (code >= 8'h04 && code <= 8'h1D) begin
         if (ctrl)       ch = code - 8'h03;   // 0x04 -> 0x01
         else if (shift) ch = code + 8'h3D;   // 0x04 -> 'A'
         else            ch = code + 8'h5D;   // 0x04 -> 'a'
      end else if (code >= 8'h1E && code <= 8'h26 && !shift) begin
         ch = code + 8'h13;                   // 0x1E -> '1'
      end else begin
         case (code)
            8'h1E: ch = 8'h21;
            8'h1F: ch = 8'h40;
            8'h20: ch = 8'h23;
            8'h21: ch = 8'h24;
            8'h22: ch = 8'h25;
            8'h23: ch = 8'h5E;
            8'h24: ch = 8'h26;
            8'h25: ch = 8'h2A;
            8'h26: ch = 8'h28;
            8'h27: ch = shift ? 8'h29 : 8'h30;
            8'h28: ch = 8'h0D;
            8'h29: ch = 8'h1B;
            8'h2A: ch = 8'h08;
            8'h2B: ch = 8'h09;
            8'h2C: ch = 8'h20;
            8'h2D: ch = shift ? 8'h5F : 8'h2D;
            8'h2E: ch = shift ? 8'h2B : 8'h3D;
            8'h2F: ch = shift ? 8'h7B : 8'h5B;
            8'h30: ch = shift ? 8'h7D : 8'h5D;
            8'h31: ch = shift ? 8'h7C : 8'h5C;
            8'h32: ch = shift ? 8'h7E : 8'h23;
            8'h33: ch = shift ? 8'h3A : 8'h3B;
            8'h34: ch = shift ? 8'h22 : 8'h27;
            8'h35: ch = shift ? 8'h7E : 8'h60;
            8'h36: ch = shift ? 8'h3C : 8'h2C;
            8'h37: ch = shift ? 8'h3E : 8'h2E;
            8'h38: ch = shift ? 8'h3F : 8'h2F;
            8'h4C: ch = 8'h7F;
            8'h4F: ch = 8'h1D;
            8'h50: ch = 8'h1C;
            8'h51: ch = 8'h1F;
            8'h52: ch = 8'h1E;
            default: ch = '0;
         endcase
      end
      return ch;
   endfunction

   // ---------------------------------------------------------------- state
   state_t      r_state;
   logic [7:0]  r_cur  [4];
   logic [7:0]  r_prev [4];
   logic [7:0]  r_mod;
   logic [1:0]  r_idx;
   logic        r_pending;
   logic        r_cs_d;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_ovf;

   logic       w_kbd;
   logic [7:0] w_slot;
   logic [7:0] w_char;
   logic       w_in_prev;
   logic       w_rollover;
   logic       w_scan_push;
   logic       w_push;
   logic [7:0] w_push_data;
   logic       w_access;
   logic       w_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_flush;
   logic       w_clr_ovf;
   logic       w_push_ok;

   assign w_kbd  = (typ_i == 2'd1);
   assign w_slot = r_cur[r_idx];
   assign w_char = f_translate(w_slot, r_mod);

   always_comb begin
      w_in_prev  = 1'b0;
      w_rollover = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (r_prev[k] == w_slot) w_in_prev = 1'b1;
         if (r_cur[k] == 8'h01)   w_rollover = 1'b1;
      end
   end

   assign w_scan_push = (r_state == S_SCAN) && !w_rollover && (w_slot != 8'h00)
                        && !w_in_prev && (w_char != 8'h00);

   // ---------------------------------------------------------- bus window
   assign w_access  = kbd_cs & ~r_cs_d;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_pop     = w_access & R_W_n & (reg_addr_i == 8'h01) & ~w_empty;
   assign w_flush   = w_access & ~R_W_n & (reg_addr_i == 8'h01);
   assign w_clr_ovf = w_access & R_W_n & (reg_addr_i == 8'h00);
   // a full FIFO drops the push even if a pop happens in the same cycle
   assign w_push_ok = w_push & ~w_full;

   always_comb begin
      data_o = '0;
      case (reg_addr_i)
         8'h00:   data_o = {6'b0, r_ovf, ~w_empty};
         8'h01:   data_o = w_empty ? 8'h00 : r_mem[r_rptr];
         default: data_o = '0;
      endcase
   end

   // ------------------------------------------------------------ scan FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_pending <= 1'b0;
         r_mod     <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            r_cur[k]  <= '0;
            r_prev[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((report_i || r_pending) && w_kbd) begin
                  r_cur[0]  <= key1_i;
                  r_cur[1]  <= key2_i;
                  r_cur[2]  <= key3_i;
                  r_cur[3]  <= key4_i;
                  r_mod     <= key_modifiers_i;
                  r_idx     <= '0;
                  r_pending <= 1'b0;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (report_i && w_kbd) r_pending <= 1'b1;
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               if (report_i && w_kbd) r_pending <= 1'b1;
               if (!w_rollover) begin
                  for (int unsigned k = 0; k < 4; k++) r_prev[k] <= r_cur[k];
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // a non-keyboard device forgets held keys, overriding COMMIT
         if (!w_kbd) begin
            for (int unsigned k = 0; k < 4; k++) r_prev[k] <= '0;
         end
      end
   end

   // ----------------------------------------------------------------- FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cs_d  <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_cs_d <= kbd_cs;
         if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
            if (w_push_ok && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push_ok && w_pop) r_count <= r_count - CNT_ONE;
         end
         // overflow set wins over a same-cycle status read
         if (w_push && w_full && !w_flush) r_ovf <= 1'b1;
         else if (w_clr_ovf)                r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !w_flush && w_push_ok) r_mem[r_wptr] <= w_push_data;
   end

`ifdef KBD_REPEAT_EN
   // ---------------------------------------------------------- auto-repeat
   logic [7:0]  r_rep_char;
   logic [7:0]  r_rep_code;
   logic        r_rep_valid;
   logic [31:0] r_rep_cnt;
   logic        r_rep_req;
   logic [7:0]  r_rep_req_char;

   logic w_rep_in_prev;
   logic w_rep_in_cur;
   logic w_rep_fire;
   logic w_rep_push;
   logic w_rep_cancel;

   always_comb begin
      w_rep_in_prev = 1'b0;
      w_rep_in_cur  = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (r_prev[k] == r_rep_code) w_rep_in_prev = 1'b1;
         if (r_cur[k]  == r_rep_code) w_rep_in_cur  = 1'b1;
      end
   end

   assign w_rep_fire   = r_rep_valid && (r_rep_cnt == '0) && w_rep_in_prev && !r_rep_req;
   // a repeat colliding with a scan push is parked in r_rep_req for later
   assign w_rep_push   = (r_rep_req || w_rep_fire) && !w_scan_push;
   assign w_rep_cancel = !w_kbd ||
                         ((r_state == S_COMMIT) && (w_rollover || !w_rep_in_cur));

   assign w_push      = w_scan_push | w_rep_push;
   assign w_push_data = w_scan_push ? w_char : (r_rep_req ? r_rep_req_char : r_rep_char);

   always_ff @(posedge clk_i) begin
      if (rst_i || w_rep_cancel) begin
         r_rep_valid    <= 1'b0;
         r_rep_cnt      <= '0;
         r_rep_req      <= 1'b0;
         r_rep_char     <= '0;
         r_rep_code     <= '0;
         r_rep_req_char <= '0;
      end else begin
         if (w_scan_push) begin
            r_rep_char  <= w_char;
            r_rep_code  <= w_slot;
            r_rep_valid <= 1'b1;
            r_rep_cnt   <= 32'(REPEAT_DELAY_CYC) - 32'd1;
         end else if (w_rep_push) begin
            r_rep_cnt <= 32'(REPEAT_RATE_CYC) - 32'd1;
         end else if (r_rep_cnt != '0) begin
            r_rep_cnt <= r_rep_cnt - 32'd1;
         end
         if (w_rep_fire && w_scan_push) begin
            r_rep_req      <= 1'b1;
            r_rep_req_char <= r_rep_char;
         end else if (w_rep_push) begin
            r_rep_req <= 1'b0;
         end
      end
   end
`else
   assign w_push      = w_scan_push;
   assign w_push_data = w_char;

   // repeat parameters stay on the interface but drive nothing here
   logic w_unused_params;
   assign w_unused_params = ^{32'(REPEAT_DELAY_CYC), 32'(REPEAT_RATE_CYC)};
`endif

endmodule

// File: tb/tb_usb_kbd_ascii.sv
module tb_usb_kbd_ascii;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       report;
  logic [1:0] typ;
  logic [7:0] mods;
  logic [7:0] key1, key2, key3, key4;
  logic       cs;
  logic       rw_n;
  logic [7:0] addr;
  logic [7:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_prev [4];
  bit         m_ovf;
  logic [7:0] rk [4];

  always #5 clk = ~clk;

  usb_kbd_ascii #(
    .FIFO_DEPTH      (DEPTH),
    .REPEAT_DELAY_CYC(10),
    .REPEAT_RATE_CYC (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .report_i       (report),
    .typ_i          (typ),
    .key_modifiers_i(mods),
    .key1_i         (key1),
    .key2_i         (key2),
    .key3_i         (key3),
    .key4_i         (key4),
    .kbd_cs         (cs),
    .R_W_n          (rw_n),
    .reg_addr_i     (addr),
    .data_o         (data_o)
  );

  initial begin
    #900000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic [7:0] m);
    string dig_n, dig_s;
    logic [7:0] pun_n [12];
    logic [7:0] pun_s [12];
    bit ctrl, shift;
    int idx;
    dig_n = "1234567890";
    dig_s = "!@#$%^&*()";
    pun_n = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h23,
              8'h3B, 8'h27, 8'h60, 8'h2C, 8'h2E, 8'h2F};
    pun_s = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h7E,
              8'h3A, 8'h22, 8'h7E, 8'h3C, 8'h3E, 8'h3F};
    ctrl  = m[0] | m[4];
    shift = m[1] | m[5];
    if (code inside {[8'h04:8'h1D]}) begin
      idx = int'(code) - 4;
      if (ctrl)  return 8'(idx + 1);
      if (shift) return 8'(idx + 65);
      return 8'(idx + 97);
    end
    if (code inside {[8'h1E:8'h27]}) begin
      idx = int'(code) - 'h1E;
      return shift ? dig_s[idx] : dig_n[idx];
    end
    if (code inside {[8'h2D:8'h38]}) begin
      idx = int'(code) - 'h2D;
      return shift ? pun_s[idx] : pun_n[idx];
    end
    case (code)
      8'h28: return 8'h0D;
      8'h29: return 8'h1B;
      8'h2A: return 8'h08;
      8'h2B: return 8'h09;
      8'h2C: return 8'h20;
      8'h4C: return 8'h7F;
      8'h4F: return 8'h1D;
      8'h50: return 8'h1C;
      8'h51: return 8'h1F;
      8'h52: return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit in_prev(input logic [7:0] code);
    foreach (m_prev[i]) if (m_prev[i] == code) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input logic [7:0] c);
    if (q.size() < DEPTH) q.push_back(c);
    else m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    foreach (m_prev[i]) m_prev[i] = 8'h00;
    m_ovf = 1'b0;
  endtask

  task automatic model_report(input logic [7:0] k1, k2, k3, k4, m);
    logic [7:0] k [4];
    logic [7:0] c;
    k = '{k1, k2, k3, k4};
    foreach (k[i]) if (k[i] == 8'h01) return;
    foreach (k[i]) begin
      c = ref_ascii(k[i], m);
      if (k[i] != 8'h00 && !in_prev(k[i]) && c != 8'h00) model_push(c);
    end
    m_prev = k;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    cs = 1'b1; rw_n = 1'b1; addr = a;
    #1 check(tag, data_o, exp);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a);
    @(negedge clk);
    cs = 1'b1; rw_n = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rw_n = 1'b1;
  endtask

  task automatic check_status(input string tag);
    bus_read(8'h00, {6'b0, m_ovf, q.size() != 0}, tag);
    m_ovf = 1'b0;
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] exp;
    exp = (q.size() != 0) ? q.pop_front() : 8'h00;
    bus_read(8'h01, exp, tag);
  endtask

  task automatic send_report(input logic [7:0] k1, k2, k3, k4, m);
    @(negedge clk);
    key1 = k1; key2 = k2; key3 = k3; key4 = k4; mods = m;
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    repeat (7) @(negedge clk);
    if (typ == 2'd1) model_report(k1, k2, k3, k4, m);
  endtask

  initial begin
    rst = 1'b1; report = 1'b0; typ = 2'd1; mods = '0;
    key1 = '0; key2 = '0; key3 = '0; key4 = '0;
    cs = 1'b0; rw_n = 1'b1; addr = '0;
    foreach (rk[i]) rk[i] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bus_read(8'h00, 8'h00, "rst_status");
    bus_read(8'h01, 8'h00, "rst_head");

`ifdef KBD_REPEAT_EN
    @(negedge clk);
    key1 = 8'h04; report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    repeat (10) @(negedge clk);
    key1 = 8'h00; report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(8'h01, 8'h61, "rep_first");
    bus_read(8'h01, 8'h61, "rep_delay");
    bus_read(8'h01, 8'h61, "rep_rate");
    bus_read(8'h00, 8'h00, "rep_stopped");
`else
    send_report(8'h04, 0, 0, 0, 8'h00);
    check_status("t1_status");
    check_pop("t1_pop");
    check_status("t1_empty");

    send_report(8'h00, 0, 0, 0, 8'h00);
    send_report(8'h04, 0, 0, 0, 8'h02);
    send_report(8'h04, 0, 0, 0, 8'h02);
    send_report(8'h04, 8'h05, 0, 0, 8'h02);
    check_pop("t2_pop0");
    check_pop("t2_pop1");
    check_status("t2_only_two");

    send_report(8'h00, 0, 0, 0, 8'h00);
    send_report(8'h06, 0, 0, 0, 8'h01);
    send_report(8'h1E, 0, 0, 0, 8'h20);
    send_report(8'h01, 8'h07, 0, 0, 8'h00);
    send_report(8'h1E, 8'h07, 0, 0, 8'h00);
    check_pop("t3_ctrl_c");
    check_pop("t3_bang");
    check_pop("t3_after_roll");
    check_status("t3_empty");

    send_report(8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) begin
      send_report(8'h04, 0, 0, 0, 8'h00);
      send_report(8'h00, 0, 0, 0, 8'h00);
    end
    check_status("t4_ovf");
    check_status("t4_ovf_cleared");
    bus_write(8'h00);
    check_status("t4_write00_ignored");
    bus_read(8'h07, 8'h00, "t4_addr07");
    bus_write(8'h01);
    q.delete();
    check_status("t4_flushed");
    check_pop("t4_empty_head");

    @(negedge clk);
    key1 = 8'h04; key2 = 8'h00; key3 = 8'h00; key4 = 8'h00; mods = 8'h00;
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    @(negedge clk);
    key2 = 8'h05; report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    repeat (14) @(negedge clk);
    model_report(8'h04, 0, 0, 0, 8'h00);
    model_report(8'h04, 8'h05, 0, 0, 8'h00);
    check_pop("t5_pend0");
    check_pop("t5_pend1");
    check_status("t5_empty");

    send_report(8'h00, 0, 0, 0, 8'h00);
    send_report(8'h06, 0, 0, 0, 8'h00);
    @(negedge clk);
    key1 = 8'h07; key2 = 8'h06; mods = 8'h00; report = 1'b1;
    @(negedge clk);
    report = 1'b0; cs = 1'b1; rw_n = 1'b1; addr = 8'h01;
    #1 check("t6_pop_head", data_o, q.pop_front());
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    model_report(8'h07, 8'h06, 0, 0, 8'h00);
    check_status("t6_count_kept");
    check_pop("t6_pushed");
    check_status("t6_empty");

    @(negedge clk);
    typ = 2'd2;
    foreach (m_prev[i]) m_prev[i] = 8'h00;
    send_report(8'h05, 0, 0, 0, 8'h00);
    @(negedge clk);
    typ = 2'd1;
    send_report(8'h07, 0, 0, 0, 8'h00);
    check_pop("t7_repress");
    check_status("t7_empty");

    @(negedge clk);
    key1 = 8'h04; key2 = 8'h00; report = 1'b1;
    @(negedge clk);
    report = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    check_status("t8_reset_scan");
    send_report(8'h04, 0, 0, 0, 8'h00);
    check_pop("t8_after_reset");

    for (int it = 0; it < 300; it++) begin
      int r;
      for (int s = 0; s < 4; s++) begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      rk[s] = rk[s];
        else if (r < 60) rk[s] = 8'h00;
        else if (r < 62) rk[s] = 8'h01;
        else             rk[s] = 8'($urandom_range(2, 'h60));
      end
      send_report(rk[0], rk[1], rk[2], rk[3], 8'($urandom));
      check_status("rnd_status");
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = int'($urandom_range(1, 6));
        for (int j = 0; j < n; j++) check_pop("rnd_pop");
      end
      if ($urandom_range(0, 19) == 0) begin
        bus_write(8'h01);
        q.delete();
      end
    end
    while (q.size() != 0) check_pop("final_drain");
    check_status("final_empty");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_kbd_ascii.md
Name: usb_kbd_ascii

Overview:
- Sits directly downstream of the USB HID host interface in the clk_i domain.
- Consumes keyboard reports (report pulse, key1..key4, modifiers, device type) and detects newly pressed keys.
- Translates HID usage codes to ASCII (US layout) and buffers the characters in a FIFO that the 6502 reads through a two-register window.

Parameters:
- FIFO_DEPTH, 16, character FIFO entries; power of two, 2..256.
- REPEAT_DELAY_CYC, 12500000, clk_i cycles before auto-repeat starts (KBD_REPEAT_EN only).
- REPEAT_RATE_CYC, 2500000, clk_i cycles between repeats (KBD_REPEAT_EN only).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- report_i  in  1  one-cycle pulse per HID report; already synchronous to clk_i.
- typ_i  in  2  device type: 0 none, 1 keyboard, 2 mouse, 3 gamepad.
- key_modifiers_i  in  8  HID modifier byte.
- key1_i..key4_i  in  8 each  HID usage codes of held keys; 0 means empty slot.
- kbd_cs  in  1  chip select.
- R_W_n  in  1  1 = read, 0 = write.
- reg_addr_i  in  8  register address.
- data_o  out  8  read data (combinational).

Behaviour:
Register map:
- 00: status {6'b0, ovf, not_empty}.
- 01: FIFO head; returns 0 when empty.
- Others read 0.

Bus access:
- An access is the first clk_i cycle with kbd_cs=1, detected by comparing against a registered copy of kbd_cs.
- Read of 01 pops one entry; no pop when empty.
- Read of 00 clears ovf on the access cycle.
- Write to 01 flushes the FIFO: pointers and count go to 0.
- Other writes are ignored.

Reset (rst_i=1 at a clock edge):
- FSM returns to IDLE; FIFO is empty; ovf=0; prev[0..3]=0; pending=0; repeat state cleared.
- data_o therefore reads 0 for addr 00/01.
- Reset mid-scan discards the report in progress.

FSM states: IDLE, SCAN, COMMIT.
- IDLE: on report_i or pending, with typ_i==1:
  - latch cur[k] <= key{k+1}_i and mod <= key_modifiers_i;
  - set idx=0, clear pending, go to SCAN.
- SCAN: one slot per cycle, idx 0..3.
  - Push translate(cur[idx], mod) if cur[idx]!=0, cur[idx] is not in prev[0..3], and the translation is nonzero.
  - After idx==3, go to COMMIT.
- COMMIT: prev <= cur; go to IDLE.
- Latency: report_i high at edge N → slot k pushed at edge N+1+k; prev updated at edge N+5.
- A report_i arriving in SCAN or COMMIT sets pending. Only one pending report is held; the keys are sampled when it is serviced.
- Rollover: if any cur[k]==8'h01 (ErrorRollOver), the report is discarded in SCAN (no pushes) and prev is unchanged.
- Device type: whenever typ_i!=1, prev is cleared and report pulses are ignored.

FIFO:
- Push when full: character dropped, ovf set (sticky).
- Push and pop in the same cycle: both take effect; count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Translation (ctrl = mod[0]|mod[4]; shift = mod[1]|mod[5]):
- 0x04-0x1D letters:
  - ctrl → 0x01-0x1A;
  - else shift → 'A'-'Z';
  - else 'a'-'z'.
- 0x1E-0x27 digits:
  - unshifted "1234567890";
  - shifted "!@#$%^&*()".
- Control keys: 0x28→0x0D, 0x29→0x1B, 0x2A→0x08, 0x2B→0x09, 0x2C→0x20, 0x4C→0x7F.
- 0x2D-0x38 punctuation:
  - unshifted "-=[]\" then 0x32 as '#', then ";'`,./";
  - shifted "_+{}|~:\"~<>?".
- Arrows: 0x4F→0x1D, 0x50→0x1C, 0x51→0x1F, 0x52→0x1E.
- Ctrl has no effect on non-letter keys.
- All other codes → 0 (dropped).

Optional Feature:
KBD_REPEAT_EN
- Defined:
  - The last pushed character and its usage code are held as the repeat key.
  - A 32-bit counter loads REPEAT_DELAY_CYC on each push.
  - When the counter reaches 0 while the usage is still in prev, the character is re-pushed and the counter reloads REPEAT_RATE_CYC.
  - Repeat is cancelled when COMMIT leaves the usage absent from prev, when typ_i!=1, on a rollover report, or on reset.
  - A repeat push colliding with a SCAN push in the same cycle is deferred one cycle.
- Undefined: no auto-repeat; counters are not synthesized; parameters are ignored.

Test Plan:
- Reset, then report with key1=0x04, mod=0x00 → FIFO holds 0x61; status reads 0x01; read 01 → 0x61; status → 0x00.
- Report key1=0x04 (mod=0x02), then an identical report, then key1=0x04 key2=0x05 → FIFO holds 0x41, 0x42 only.
- Report key1=0x06, mod=0x01 → 0x03; key1=0x1E with mod=0x20 → 0x21; key1=0x01 key2=0x07 → no push, prev unchanged.
- 17 reports alternating key1=0x04/0x00 with FIFO_DEPTH=16 and no reads → count 16, ovf=1; read 00 → 0x03, next read → 0x01; write 01 → status 0x00.
- Second report_i 2 cycles after the first (first key1=0x04, second key1=0x04 key2=0x05) → pending serviced; FIFO holds 0x61, 0x62; typ_i=2 then back to 1 with key1=0x04 → 0x61 pushed again.
- With KBD_REPEAT_EN, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=4, key1=0x04 held → 0x61 at push, again 10 cycles later, then every 4; release report → repeats stop.
